// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Serial bit-pattern detector. It accepts one bit per clock while `en` is high
// and flags every occurrence of PATTERN, with the MSB of PATTERN as the first
// bit received. It also keeps a saturating count of matches.
//
// Parameters
//   N        pattern length in bits (2..16)
//   PATTERN  N-bit pattern, MSB first on the wire
//   OVERLAP  1: the trailing bits of a match may start the next match
//            0: N fresh bits are required after each match
//   MOORE    0: combinational (Mealy) z, 1: registered (Moore) z
//   CNT_W    width of match_cnt
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   x          in   serial data bit
//   en         in   x is valid this cycle; otherwise all state holds
//   z          out  match indication
//   match_cnt  out  matches since reset, saturating at all-ones
// -----------------------------------------------------------------------------
module seq_detector_param #(
  parameter int unsigned    N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter bit             MOORE   = 1'b0,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             en,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned       FILL_W   = $clog2(N + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N);
  localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(N - 1);

  // Only the N-1 most recent accepted bits are stored. Together with the bit
  // being presented they form the N-bit window that is compared.
  logic [N-2:0]     hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  logic [N-1:0]     window;
  logic             hit;

  assign window = {hist_q, x};

  // fill gating stops stale or reset-valued history from matching. This
  // matters most for all-zero patterns and for bits accepted before reset.
  assign hit = en & ~reset & (fill_q >= FILL_THR) & (window == PATTERN);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (en) begin
      hist_d = window[N-2:0];
      if (hit && !OVERLAP) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
      if (hit && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;

  generate
    if (MOORE) begin : g_moore
      logic z_q;
      // Loaded on every edge, so an en=0 cycle after a match clears it.
      always_ff @(posedge clk) begin
        if (reset) begin
          z_q <= 1'b0;
        end else begin
          z_q <= hit;
        end
      end
      assign z = z_q;
    end else begin : g_mealy
      assign z = hit;
    end
  endgenerate

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  localparam int ID_A = 0;  // 1011, overlap, Mealy
  localparam int ID_B = 1;  // 1011, non-overlap, Mealy
  localparam int ID_C = 2;  // 1011, overlap, Moore
  localparam int ID_D = 3;  // 1111, overlap, CNT_W=2
  localparam int ID_E = 4;  // 1111, non-overlap, CNT_W=2
  localparam int ID_F = 5;  // 0000, overlap, Mealy

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] rst_v = '1;
  logic [5:0] en_v  = '0;
  logic [5:0] x_v   = '0;
  logic [5:0] z_v;
  logic [7:0] cnt_a, cnt_b, cnt_c, cnt_f;
  logic [1:0] cnt_d, cnt_e;

  seq_detector_param u_a (.clk(clk), .reset(rst_v[ID_A]), .x(x_v[ID_A]), .en(en_v[ID_A]),
                          .z(z_v[ID_A]), .match_cnt(cnt_a));
  seq_detector_param #(.OVERLAP(1'b0)) u_b (.clk(clk), .reset(rst_v[ID_B]), .x(x_v[ID_B]),
                          .en(en_v[ID_B]), .z(z_v[ID_B]), .match_cnt(cnt_b));
  seq_detector_param #(.MOORE(1'b1)) u_c (.clk(clk), .reset(rst_v[ID_C]), .x(x_v[ID_C]),
                          .en(en_v[ID_C]), .z(z_v[ID_C]), .match_cnt(cnt_c));
  seq_detector_param #(.PATTERN(4'b1111), .CNT_W(2)) u_d (.clk(clk), .reset(rst_v[ID_D]),
                          .x(x_v[ID_D]), .en(en_v[ID_D]), .z(z_v[ID_D]), .match_cnt(cnt_d));
  seq_detector_param #(.PATTERN(4'b1111), .OVERLAP(1'b0), .CNT_W(2)) u_e (.clk(clk),
                          .reset(rst_v[ID_E]), .x(x_v[ID_E]), .en(en_v[ID_E]), .z(z_v[ID_E]),
                          .match_cnt(cnt_e));
  seq_detector_param #(.PATTERN(4'b0000)) u_f (.clk(clk), .reset(rst_v[ID_F]), .x(x_v[ID_F]),
                          .en(en_v[ID_F]), .z(z_v[ID_F]), .match_cnt(cnt_f));

  typedef struct {
    int    id;
    logic  z;
    int    cnt;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   seq_no   = 0;

  function automatic int cnt_of(input int id);
    case (id)
      ID_A:    return int'(cnt_a);
      ID_B:    return int'(cnt_b);
      ID_C:    return int'(cnt_c);
      ID_D:    return int'(cnt_d);
      ID_E:    return int'(cnt_e);
      default: return int'(cnt_f);
    endcase
  endfunction

  // One cycle of stimulus for instance `id`. All other instances stay in reset.
  // The expected z and match_cnt are the values the DUT must show while these
  // inputs are applied, before the next rising edge.
  task automatic s(input int id, input bit r, input bit e, input bit xv,
                   input bit ez, input int ec, input string tag);
    exp_t ex;
    @(posedge clk);
    #1;
    rst_v     = '1;
    en_v      = '0;
    x_v       = '0;
    rst_v[id] = r;
    en_v[id]  = e;
    x_v[id]   = xv;
    ex.id  = id;
    ex.z   = ez;
    ex.cnt = ec;
    ex.tag = tag;
    sb.push_back(ex);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    exp_t ex;
    int   act_cnt;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        ex      = sb.pop_front();
        seq_no  = seq_no + 1;
        act_cnt = cnt_of(ex.id);
        n_checks = n_checks + 1;
        if (z_v[ex.id] !== ex.z) begin
          n_fail = n_fail + 1;
          $display("FAIL %s #%0d z: got %b expected %b", ex.tag, seq_no, z_v[ex.id], ex.z);
        end
        n_checks = n_checks + 1;
        if (act_cnt != ex.cnt) begin
          n_fail = n_fail + 1;
          $display("FAIL %s #%0d match_cnt: got %0d expected %0d", ex.tag, seq_no, act_cnt, ex.cnt);
        end
      end
    end
  end

  initial begin : stim
    // Default detector: reset, reset together with en (discarded), then the stream 1011011.
    s(ID_A,1,0,0, 0,0,"a_rst"); s(ID_A,1,0,0, 0,0,"a_rst"); s(ID_A,1,1,1, 0,0,"a_rst_en");
    s(ID_A,0,1,1, 0,0,"a_main"); s(ID_A,0,1,0, 0,0,"a_main"); s(ID_A,0,1,1, 0,0,"a_main");
    s(ID_A,0,1,1, 1,0,"a_main"); s(ID_A,0,1,0, 0,1,"a_main"); s(ID_A,0,1,1, 0,1,"a_main");
    s(ID_A,0,1,1, 1,1,"a_main"); s(ID_A,0,0,1, 0,2,"a_main");
    // en gaps: 1,(gap),0,1,(gap with x=1),1 -> one match on the last bit.
    s(ID_A,1,0,0, 0,2,"a_gap_rst");
    s(ID_A,0,1,1, 0,0,"a_gap"); s(ID_A,0,0,0, 0,0,"a_gap"); s(ID_A,0,1,0, 0,0,"a_gap");
    s(ID_A,0,1,1, 0,0,"a_gap"); s(ID_A,0,0,1, 0,0,"a_gap"); s(ID_A,0,1,1, 1,0,"a_gap");
    s(ID_A,0,0,0, 0,1,"a_gap");
    // Reset mid-pattern: 1,0,1, reset (with en), 1 -> no match; then 0,1,1 -> match.
    s(ID_A,1,0,0, 0,1,"a_mid_rst");
    s(ID_A,0,1,1, 0,0,"a_mid"); s(ID_A,0,1,0, 0,0,"a_mid"); s(ID_A,0,1,1, 0,0,"a_mid");
    s(ID_A,1,1,1, 0,0,"a_mid_rst_en"); s(ID_A,0,1,1, 0,0,"a_mid_after");
    s(ID_A,0,1,0, 0,0,"a_mid_after"); s(ID_A,0,1,1, 0,0,"a_mid_after");
    s(ID_A,0,1,1, 1,0,"a_mid_after"); s(ID_A,0,0,0, 0,1,"a_mid_after");

    // Non-overlap: 1011011 then 011011 -> matches at bits 4 and 10 only.
    s(ID_B,1,0,0, 0,0,"b_rst");
    s(ID_B,0,1,1, 0,0,"b_nov"); s(ID_B,0,1,0, 0,0,"b_nov"); s(ID_B,0,1,1, 0,0,"b_nov");
    s(ID_B,0,1,1, 1,0,"b_nov"); s(ID_B,0,1,0, 0,1,"b_nov"); s(ID_B,0,1,1, 0,1,"b_nov");
    s(ID_B,0,1,1, 0,1,"b_nov"); s(ID_B,0,1,0, 0,1,"b_nov"); s(ID_B,0,1,1, 0,1,"b_nov");
    s(ID_B,0,1,1, 1,1,"b_nov"); s(ID_B,0,1,0, 0,2,"b_nov"); s(ID_B,0,1,1, 0,2,"b_nov");
    s(ID_B,0,1,1, 0,2,"b_nov"); s(ID_B,0,0,0, 0,2,"b_nov");

    // Moore: z is a one-cycle pulse after each accepting edge. An en=0 cycle clears it.
    s(ID_C,1,0,0, 0,0,"c_rst");
    s(ID_C,0,1,1, 0,0,"c_moore"); s(ID_C,0,1,0, 0,0,"c_moore"); s(ID_C,0,1,1, 0,0,"c_moore");
    s(ID_C,0,1,1, 0,0,"c_moore"); s(ID_C,0,1,0, 1,1,"c_moore"); s(ID_C,0,1,1, 0,1,"c_moore");
    s(ID_C,0,1,1, 0,1,"c_moore"); s(ID_C,0,0,0, 1,2,"c_moore"); s(ID_C,0,0,0, 0,2,"c_moore");

    // 1111 overlap: seven ones -> four matches, 2-bit count saturates at 3.
    s(ID_D,1,0,0, 0,0,"d_rst");
    s(ID_D,0,1,1, 0,0,"d_ones"); s(ID_D,0,1,1, 0,0,"d_ones"); s(ID_D,0,1,1, 0,0,"d_ones");
    s(ID_D,0,1,1, 1,0,"d_ones"); s(ID_D,0,1,1, 1,1,"d_ones"); s(ID_D,0,1,1, 1,2,"d_ones");
    s(ID_D,0,1,1, 1,3,"d_sat"); s(ID_D,0,0,0, 0,3,"d_sat");

    // 1111 non-overlap: eight ones -> matches at bits 4 and 8.
    s(ID_E,1,0,0, 0,0,"e_rst");
    s(ID_E,0,1,1, 0,0,"e_ones"); s(ID_E,0,1,1, 0,0,"e_ones"); s(ID_E,0,1,1, 0,0,"e_ones");
    s(ID_E,0,1,1, 1,0,"e_ones"); s(ID_E,0,1,1, 0,1,"e_ones"); s(ID_E,0,1,1, 0,1,"e_ones");
    s(ID_E,0,1,1, 0,1,"e_ones"); s(ID_E,0,1,1, 1,1,"e_ones"); s(ID_E,0,0,0, 0,2,"e_ones");

    // All-zero pattern must not match on the reset value of the history.
    s(ID_F,1,0,0, 0,0,"f_rst");
    s(ID_F,0,1,0, 0,0,"f_zero"); s(ID_F,0,1,0, 0,0,"f_zero"); s(ID_F,0,1,0, 0,0,"f_zero");
    s(ID_F,0,1,0, 1,0,"f_zero"); s(ID_F,0,0,0, 0,1,"f_zero");

    // Wait a bounded time for the monitor to drain the scoreboard.
    repeat (3) @(posedge clk);
    n_checks = n_checks + 1;
    if (sb.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
